// File: rtl/calc_sequencer.sv
// calc_sequencer: control unit for a 16x8 instruction memory and a 16x8 data
// memory. It fetches, decodes and executes 8-bit instructions against an
// 8-bit accumulator until a HALT opcode, then pulses done.
// Optional build macro CALC_WDOG_EN adds an instruction-count watchdog and
// the wdog output port.
module calc_sequencer #(
  parameter int                ADDR_W     = 4,
  parameter int                DATA_W     = 8,
  parameter logic [ADDR_W-1:0] START_PC   = '0,
  parameter int                WDOG_LIMIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic              data_we,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic              zero,
  output logic              carry
`ifdef CALC_WDOG_EN
  ,
  output logic              wdog
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_WRITE  = 3'd5;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_LDI   = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [DATA_W-1:0] ir;
  logic [3:0]        dec_op;
  logic [ADDR_W-1:0] dec_arg;
  logic [3:0]        exe_op;
  logic [DATA_W:0]   alu_res;
  logic              wdog_trip;

  // Decode straight off the memory output; ir keeps the opcode for EXEC.
  assign dec_op  = inst_rdata[DATA_W-1 -: 4];
  assign dec_arg = inst_rdata[ADDR_W-1:0];
  assign exe_op  = ir[DATA_W-1 -: 4];

  assign busy       = (state != S_IDLE);
  assign inst_addr  = pc;
  assign data_wdata = acc;
  // Combinational from state so an async reset drops the strobe at once.
  assign data_we    = (state == S_WRITE);

  // Operand field of ir is only consumed through data_addr.
  logic unused_ir;
  assign unused_ir = ^ir[DATA_W-5:0];

`ifdef CALC_WDOG_EN
  logic [7:0] icount;

  assign wdog_trip = (icount >= 8'(WDOG_LIMIT));

  // Instruction counter and sticky watchdog flag, both cleared on start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      icount <= '0;
      wdog   <= 1'b0;
    end else if (state == S_IDLE) begin
      if (start) begin
        icount <= '0;
        wdog   <= 1'b0;
      end
    end else if (state == S_DECODE) begin
      icount <= icount + 8'd1;
    end else if (state == S_FETCH && wdog_trip) begin
      wdog <= 1'b1;
    end
  end
`else
  logic unused_wdog_cfg;
  assign wdog_trip       = 1'b0;
  assign unused_wdog_cfg = (WDOG_LIMIT != 0);
`endif

  // EXEC result: {carry, acc}; non-arithmetic ops carry the old carry through.
  always_comb begin
    alu_res = {carry, acc};
    case (exe_op)
      OP_LOAD: alu_res = {carry, data_rdata};
      OP_ADD:  alu_res = {1'b0, acc} + {1'b0, data_rdata};
      OP_SUB:  alu_res = {1'b0, acc} - {1'b0, data_rdata};
      OP_AND:  alu_res = {carry, acc & data_rdata};
      OP_OR:   alu_res = {carry, acc | data_rdata};
      OP_XOR:  alu_res = {carry, acc ^ data_rdata};
      default: alu_res = {carry, acc};
    endcase
  end

  // Next-state selection; memory ops detour through READ/EXEC or WRITE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  state_next = wdog_trip ? S_IDLE : S_DECODE;
      S_DECODE: begin
        case (dec_op)
          OP_LOAD, OP_ADD, OP_SUB,
          OP_AND, OP_OR, OP_XOR: state_next = S_READ;
          OP_STORE:              state_next = S_WRITE;
          OP_HALT:               state_next = S_IDLE;
          default:               state_next = S_FETCH;
        endcase
      end
      S_READ:   state_next = S_EXEC;
      S_EXEC:   state_next = S_FETCH;
      S_WRITE:  state_next = S_FETCH;
      default:  state_next = S_IDLE;
    endcase
  end

  // Sequencer registers: pc, acc, flags, instruction and data address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pc        <= START_PC;
      acc       <= '0;
      ir        <= '0;
      data_addr <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      zero      <= 1'b0;
      carry     <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= START_PC;
            acc   <= '0;
            err   <= 1'b0;
            zero  <= 1'b0;
            carry <= 1'b0;
          end
        end
        S_DECODE: begin
          ir        <= inst_rdata;
          data_addr <= dec_arg;
          pc        <= pc + ADDR_W'(1);
          case (dec_op)
            OP_LDI: begin
              acc  <= {{(DATA_W-ADDR_W){1'b0}}, dec_arg};
              zero <= (dec_arg == '0);
            end
            OP_JMP:  pc <= dec_arg;
            OP_JZ:   if (zero) pc <= dec_arg;
            OP_HALT: done <= 1'b1;
            4'hB, 4'hC, 4'hD, 4'hE: err <= 1'b1;
            default: ;
          endcase
        end
        S_EXEC: begin
          acc   <= alu_res[DATA_W-1:0];
          carry <= alu_res[DATA_W];
          zero  <= (alu_res[DATA_W-1:0] == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: models both memories, runs short programs and
// compares the end-of-run state against an instruction-level reference model
// through a scoreboard queue. Define CALC_WDOG_EN to also exercise the watchdog.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err, data_we, zero, carry;
  logic [3:0]  inst_addr, data_addr, pc;
  logic [7:0]  inst_rdata, data_rdata, data_wdata, acc;
`ifdef CALC_WDOG_EN
  logic        wdog;
`endif

  calc_sequencer #(.WDOG_LIMIT(20)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .inst_addr(inst_addr), .inst_rdata(inst_rdata), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_we(data_we), .data_rdata(data_rdata),
    .acc(acc), .pc(pc), .zero(zero), .carry(carry)
`ifdef CALC_WDOG_EN
    , .wdog(wdog)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] imem [16];
  logic [7:0] dmem [16];

  // Synchronous-read memories, one cycle of read latency.
  always @(posedge clk) begin
    inst_rdata <= imem[inst_addr];
    data_rdata <= dmem[data_addr];
    if (data_we) dmem[data_addr] <= data_wdata;
  end

  typedef struct packed {
    logic [7:0]       acc;
    logic             zero;
    logic             carry;
    logic             err;
    logic [3:0]       pc;
    logic [15:0]      cycles;
    logic [15:0][7:0] dm;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_cycles;
  int   last_dones;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instruction-level reference: final state, data memory and cycle count.
  function automatic exp_t model(input logic [15:0][7:0] im, input logic [15:0][7:0] dm_in);
    exp_t             e;
    logic [15:0][7:0] dm;
    logic [3:0]       pcv, op, a;
    logic [7:0]       av, m;
    logic [8:0]       r;
    logic             z, c, er, halted;
    int               cyc;
    dm = dm_in; pcv = 4'h0; av = 8'h00; z = 1'b0; c = 1'b0; er = 1'b0;
    halted = 1'b0; cyc = 0;
    for (int k = 0; k < 1000 && !halted; k++) begin
      op  = im[pcv][7:4];
      a   = im[pcv][3:0];
      m   = dm[a];
      pcv = pcv + 4'h1;
      case (op)
        4'h0: cyc += 2;
        4'h1: begin av = m; z = (av == 8'h00); cyc += 4; end
        4'h2: begin dm[a] = av; cyc += 3; end
        4'h3: begin r = {1'b0, av} + {1'b0, m}; c = r[8]; av = r[7:0]; z = (av == 8'h00); cyc += 4; end
        4'h4: begin r = {1'b0, av} - {1'b0, m}; c = r[8]; av = r[7:0]; z = (av == 8'h00); cyc += 4; end
        4'h5: begin av = av & m; z = (av == 8'h00); cyc += 4; end
        4'h6: begin av = av | m; z = (av == 8'h00); cyc += 4; end
        4'h7: begin av = av ^ m; z = (av == 8'h00); cyc += 4; end
        4'h8: begin av = {4'h0, a}; z = (a == 4'h0); cyc += 2; end
        4'h9: begin pcv = a; cyc += 2; end
        4'hA: begin if (z) pcv = a; cyc += 2; end
        4'hF: begin halted = 1'b1; cyc += 2; end
        default: begin er = 1'b1; cyc += 2; end
      endcase
    end
    e.acc = av; e.zero = z; e.carry = c; e.err = er; e.pc = pcv;
    e.cycles = 16'(cyc); e.dm = dm;
    return e;
  endfunction

  task automatic load_mem(input logic [15:0][7:0] p, input logic [15:0][7:0] d);
    for (int i = 0; i < 16; i++) begin
      imem[i] = p[i];
      dmem[i] <= d[i];
    end
  endtask

  // Start a run and count busy cycles until done (or until busy falls).
  task automatic launch_and_wait(input int budget, output logic finished);
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    last_cycles = 0; last_dones = 0; finished = 1'b0; n = 0;
    while (!finished && n < budget) begin
      if (busy) last_cycles++;
      if (done) last_dones++;
      if (done || !busy) finished = 1'b1;
      else @(negedge clk);
      n++;
    end
  endtask

  task automatic run_prog(input string tag, input logic [15:0][7:0] p, input logic [15:0][7:0] d);
    exp_t             e;
    logic             fin;
    logic [15:0][7:0] got_dm;
    @(negedge clk);
    load_mem(p, d);
    sb.push_back(model(p, d));
    launch_and_wait(400, fin);
    check({tag, "_done_seen"}, 128'(fin && done), 128'(1));
    e = sb.pop_front();
    for (int i = 0; i < 16; i++) got_dm[i] = dmem[i];
    check({tag, "_acc"},    128'(acc),         128'(e.acc));
    check({tag, "_zero"},   128'(zero),        128'(e.zero));
    check({tag, "_carry"},  128'(carry),       128'(e.carry));
    check({tag, "_err"},    128'(err),         128'(e.err));
    check({tag, "_pc"},     128'(pc),          128'(e.pc));
    check({tag, "_cycles"}, 128'(last_cycles), 128'(e.cycles));
    check({tag, "_busy"},   128'(busy),        128'(0));
    check({tag, "_dmem"},   128'(got_dm),      128'(e.dm));
    @(negedge clk);
    check({tag, "_done_1cyc"}, 128'(done), 128'(0));
    $display("run %s: acc=%h zero=%b carry=%b err=%b pc=%h cycles=%0d", tag, acc, zero, carry, err, pc, last_cycles);
  endtask

  logic [15:0][7:0] p, d;
  logic [3:0]       ops [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hC};

  initial begin
    for (int i = 0; i < 16; i++) begin
      imem[i] = 8'h00;
      dmem[i] = 8'h00;
    end
    inst_rdata = 8'h00;
    data_rdata = 8'h00;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy",  128'(busy),    128'(0));
    check("rst_done",  128'(done),    128'(0));
    check("rst_err",   128'(err),     128'(0));
    check("rst_we",    128'(data_we), 128'(0));
    check("rst_pc",    128'(pc),      128'(0));
    check("rst_acc",   128'(acc),     128'(0));
    check("rst_flags", 128'({zero, carry}), 128'(0));
    rst = 1'b1;
    @(negedge clk);
    $display("reset released");

    // LOAD / ADD with carry out to zero / STORE / HALT
    p = '0; d = '0;
    p[0] = 8'h10; p[1] = 8'h31; p[2] = 8'h22; p[3] = 8'hF0;
    d[0] = 8'h0F; d[1] = 8'hF1;
    run_prog("load_add_store", p, d);
    check("t1_dmem2",  128'(dmem[2]),     128'(8'h00));
    check("t1_cycles", 128'(last_cycles), 128'(13));
    check("t1_flags",  128'({zero, carry}), 128'(2'b11));
    check("t1_dones",  128'(last_dones),  128'(1));

    // LDI then SUB with borrow
    p = '0; d = '0;
    p[0] = 8'h85; p[1] = 8'h40; p[2] = 8'hF0; d[0] = 8'h07;
    run_prog("sub_borrow", p, d);
    check("t2_acc",   128'(acc), 128'(8'hFE));
    check("t2_flags", 128'({zero, carry}), 128'(2'b01));

    // JZ taken and not taken
    p = '0; d = '0;
    p[0] = 8'h80; p[1] = 8'hA3; p[2] = 8'h81; p[3] = 8'hF0;
    run_prog("jz_taken", p, d);
    check("t3_acc", 128'(acc), 128'(8'h00));
    p[0] = 8'h82;
    run_prog("jz_not_taken", p, d);
    check("t4_acc", 128'(acc), 128'(8'h01));

    // Illegal opcode sets err; next start clears it
    p = '0; d = '0;
    p[0] = 8'hB0; p[1] = 8'hF0;
    run_prog("illegal", p, d);
    check("t5_err", 128'(err), 128'(1));
    p[0] = 8'h80;
    run_prog("err_clear", p, d);
    check("t6_err", 128'(err), 128'(0));

    // Random straight-line programs ending in HALT at the last address (pc wraps)
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 15; i++) begin
        p[i] = {ops[$urandom_range(0, 9)], 4'($urandom_range(0, 15))};
        d[i] = 8'($urandom_range(0, 255));
      end
      p[15] = 8'hF0;
      d[15] = 8'($urandom_range(0, 255));
      run_prog($sformatf("random%0d", t), p, d);
    end

    // Reset during the WRITE cycle of a STORE
    begin
      logic seen;
      int   n;
      p = '0; d = '0;
      p[0] = 8'h85; p[1] = 8'h22; p[2] = 8'hF0;
      @(negedge clk);
      load_mem(p, d);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0; n = 0;
      while (!seen && n < 50) begin
        if (data_we) seen = 1'b1;
        else @(negedge clk);
        n++;
      end
      check("rstw_we_seen", 128'(seen), 128'(1));
      rst = 1'b0;
      #1;
      check("rstw_we_drop", 128'(data_we), 128'(0));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rstw_busy", 128'(busy), 128'(0));
      check("rstw_pc",   128'(pc),   128'(0));
      check("rstw_acc",  128'(acc),  128'(0));
      $display("run reset_in_write: we_seen=%b busy=%b pc=%h acc=%h", seen, busy, pc, acc);
    end

`ifdef CALC_WDOG_EN
    // Watchdog on an endless JMP 0 loop
    begin
      logic fin;
      p = '0; d = '0;
      p[0] = 8'h90;
      @(negedge clk);
      load_mem(p, d);
      launch_and_wait(400, fin);
      check("wdog_stopped", 128'(fin),         128'(1));
      check("wdog_flag",    128'(wdog),        128'(1));
      check("wdog_cycles",  128'(last_cycles), 128'(41));
      check("wdog_nodone",  128'(last_dones),  128'(0));
      check("wdog_busy",    128'(busy),        128'(0));
      $display("run watchdog: wdog=%b cycles=%0d dones=%0d", wdog, last_cycles, last_dones);
      p[0] = 8'hF0;
      run_prog("wdog_clear", p, d);
      check("wdog_cleared", 128'(wdog), 128'(0));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Control unit for the calculator's 16x8 instruction and data memories.
- On start it fetches 8-bit instructions from instruction memory and executes them against an 8-bit accumulator, reading and writing data memory.
- Runs until a HALT opcode, then pulses done.
- Sits between a host/testbench and the two memories and owns their read/write sequencing.

Parameters:
- ADDR_W, 4, address width of both memories; pc and operand field width.
- DATA_W, 8, data and instruction width; instruction = {opcode[3:0], operand[ADDR_W-1:0]}.
- START_PC, 0, pc value loaded on start.
- WDOG_LIMIT, 255, max instructions per run (only used with CALC_WDOG_EN).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  level-sampled in IDLE; begins a run.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse when HALT executes.
- err  out  1  sticky illegal-opcode flag; cleared on start.
- inst_addr  out  ADDR_W  instruction memory address (= pc).
- inst_rdata  in  DATA_W  instruction memory read data, valid 1 cycle after address.
- data_addr  out  ADDR_W  data memory address (registered operand).
- data_wdata  out  DATA_W  data memory write data (= acc).
- data_we  out  1  data memory write enable, one cycle per STORE.
- data_rdata  in  DATA_W  data memory read data, valid 1 cycle after address.
- acc  out  DATA_W  accumulator.
- pc  out  ADDR_W  program counter.
- zero  out  1  acc==0 after the last acc-modifying op.
- carry  out  1  carry/borrow from the last ADD/SUB.

Behaviour:
- Reset (rst=0, async): state=IDLE; pc=START_PC; acc=0, ir=0, data_addr=0; busy=0, done=0, err=0, data_we=0, zero=0, carry=0. Reset mid-run aborts immediately; data_we drops asynchronously.
- States: IDLE, FETCH, DECODE, READ, EXEC, WRITE.
- IDLE: if start=1, then pc=START_PC, acc=0, err/zero/carry=0, go to FETCH. start in any other state is ignored.
- FETCH: inst_addr=pc; go to DECODE.
- DECODE: ir=inst_rdata; data_addr=ir[3:0]; pc=pc+1, wrapping 4'hF to 4'h0.
  - Memory ops go to READ; STORE goes to WRITE.
  - All others execute in DECODE and go to FETCH, except HALT.
- READ: data memory addressed; go to EXEC.
- EXEC: apply data_rdata; go to FETCH.
- WRITE: data_we=1, data_wdata=acc for exactly this cycle; go to FETCH.
- Opcodes (ir[7:4]), with a = ir[3:0] and M[a] = data_rdata:
  - 0 NOP.
  - 1 LOAD: acc=M[a].
  - 2 STORE: M[a]=acc.
  - 3 ADD: {carry,acc}=acc+M[a].
  - 4 SUB: {carry,acc}=acc-M[a], carry=borrow.
  - 5 AND, 6 OR, 7 XOR: with M[a].
  - 8 LDI: acc={4'h0,a}.
  - 9 JMP: pc=a.
  - A JZ: pc=a if zero=1.
  - F HALT: done=1 for one cycle, pc holds at HALT address+1, go to IDLE.
  - B-E illegal: err=1, executed as NOP, run continues.
- Flag rules:
  - zero updates on LOAD, ADD, SUB, AND, OR, XOR, LDI.
  - carry updates only on ADD and SUB; all other ops hold it.
  - acc arithmetic is modulo 2^DATA_W.
- Latency per instruction:
  - NOP, LDI, JMP, JZ, HALT, illegal: 2 cycles.
  - STORE: 3 cycles.
  - LOAD and ALU ops: 4 cycles.
- busy=1 in every state except IDLE. done and busy=0 are coincident with IDLE entry.
- An unterminated program loops indefinitely, with pc wrapping.

Optional Feature:
- Macro: CALC_WDOG_EN.
- When defined:
  - An 8-bit instruction counter is cleared on start and increments at each DECODE.
  - When the counter reaches WDOG_LIMIT, the run aborts to IDLE at the next FETCH boundary.
  - Output port wdog (1 bit, sticky until next start) is set; done is not pulsed.
- When undefined: no counter and no wdog port; runs are unbounded.

Test Plan:
- Reset during WRITE of STORE -> data_we=0 immediately; busy=0, pc=0, acc=0 after release.
- imem {8'h10, 8'h31, 8'h22, 8'hF0}, dmem[0]=8'h0F, dmem[1]=8'hF1 -> dmem[2]=8'h00, zero=1, carry=1, done pulse once, total 4+4+3+2=13 cycles from FETCH.
- imem {8'h85, 8'h40, 8'hF0}, dmem[0]=8'h07 -> acc=8'hFE, carry=1 (borrow), zero=0.
- imem {8'h80, 8'hA3, 8'h81, 8'hF0} -> JZ taken to addr 3, acc stays 8'h00, done pulse; with 8'h82 first: not taken, acc=8'h01.
- imem {8'hB0, 8'hF0} -> err=1, done pulses; next start clears err to 0.
- CALC_WDOG_EN, WDOG_LIMIT=20, imem[0]=8'h90 (JMP 0) -> wdog=1 after 20 DECODEs, busy=0, done never pulses.
